// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux select scanner.
// Holds the scanner state encoding, the word counter width and helpers
// that derive the first and last scan index from WIDTH and MSB_FIRST.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int WORD_CNT_W = 8;

    // First index presented after a word is loaded.
    function automatic int scan_start(input int width, input bit msb_first);
        return msb_first ? (width - 1) : 0;
    endfunction

    // Final index of a word, opposite end from scan_start.
    function automatic int scan_end(input int width, input bit msb_first);
        return msb_first ? 0 : (width - 1);
    endfunction

endpackage

// File: rtl/mux_sel_scanner_counter.sv
// Loadable up/down select counter for the mux select scanner.
// Load has priority over enable. The next value is exported so the parent
// can register flags that line up with the counter output.
module mux_sel_counter #(
    parameter int SEL_W      = 3,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [SEL_W-1:0] load_val,
    input  logic [SEL_W-1:0] end_val,
    output logic [SEL_W-1:0] count_q,
    output logic [SEL_W-1:0] count_d,
    output logic             at_end
);

    // Next count: load a start value, otherwise step one index when enabled.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable) begin
            if (COUNT_DOWN) begin
                count_d = count_q - SEL_W'(1);
            end else begin
                count_d = count_q + SEL_W'(1);
            end
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_end = (count_q == end_val);

endmodule

// File: rtl/mux_sel_scanner.sv
// Upstream driver for an 8:1 style mux: accepts a word over valid/ready,
// holds it on data_out and walks sel_out through every index, one per clock.
// Back-to-back words are loaded on the last index with no idle gap.
// Optional feature macro: MUX_SEL_SCANNER_STALL_EN adds a stall input that
// freezes the scan and masks bit_valid while asserted.
module mux_sel_scanner
    import mux_scan_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int SEL_W     = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
`ifdef MUX_SEL_SCANNER_STALL_EN
    input  logic                  stall,
`endif
    output logic                  in_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  bit_valid,
    output logic                  bit_last,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    localparam logic [SEL_W-1:0] SCAN_START = SEL_W'(scan_start(WIDTH, MSB_FIRST));
    localparam logic [SEL_W-1:0] SCAN_END   = SEL_W'(scan_end(WIDTH, MSB_FIRST));

    scan_state_e           state_q, state_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  bit_last_q, bit_last_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      sel_d;
    logic                  at_end;
    logic                  stall_w;
    logic                  advance;
    logic                  scan_hold;
    logic                  word_done;
    logic                  accept;
    logic                  cnt_enable;

`ifdef MUX_SEL_SCANNER_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign advance    = (state_q == SCAN) && !stall_w;
    assign scan_hold  = (state_q == SCAN) && stall_w;
    assign word_done  = advance && at_end;
    assign in_ready   = (state_q == IDLE) || (advance && bit_last_q);
    assign accept     = in_valid && in_ready;
    assign cnt_enable = advance && !at_end;

    mux_sel_counter #(
        .SEL_W      (SEL_W),
        .COUNT_DOWN (MSB_FIRST)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .enable   (cnt_enable),
        .load_val (SCAN_START),
        .end_val  (SCAN_END),
        .count_q  (sel_q),
        .count_d  (sel_d),
        .at_end   (at_end)
    );

    // Next-state logic: load on accept, retire the word on its last index.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        bit_valid_d = bit_valid_q;
        word_cnt_d  = word_cnt_q;
        if (accept) begin
            state_d     = SCAN;
            data_d      = in_data;
            bit_valid_d = 1'b1;
        end else if (word_done) begin
            state_d     = IDLE;
            bit_valid_d = 1'b0;
        end
        if (word_done) begin
            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
        end
        if (scan_hold) begin
            bit_last_d = bit_last_q;
        end else begin
            bit_last_d = (state_d == SCAN) && (sel_d == SCAN_END);
        end
    end

    // State, data and flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bit_valid_q <= bit_valid_d;
            bit_last_q  <= bit_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign bit_valid = bit_valid_q && !stall_w;
    assign bit_last  = bit_last_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner: LSB-first and MSB-first scans, the
// attached mux output, back-to-back words, asynchronous reset mid-scan,
// word counter wrap and, when MUX_SEL_SCANNER_STALL_EN is defined, stall.
module tb_mux_sel_scanner;

    logic       clk;
    logic       rst_n;

    logic       in_valid0, in_valid1;
    logic [7:0] in_data0, in_data1;
    logic       stall0, stall1;
    logic       ready0, ready1;
    logic [7:0] data0, data1;
    logic [2:0] sel0, sel1;
    logic       bv0, bv1;
    logic       bl0, bl1;
    logic [7:0] cnt0, cnt1;

    int compared;
    int mismatched;

    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;

    mux_sel_scanner #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_data   (in_data0),
`ifdef MUX_SEL_SCANNER_STALL_EN
        .stall     (stall0),
`endif
        .in_ready  (ready0),
        .data_out  (data0),
        .sel_out   (sel0),
        .bit_valid (bv0),
        .bit_last  (bl0),
        .word_cnt  (cnt0)
    );

    mux_sel_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
`ifdef MUX_SEL_SCANNER_STALL_EN
        .stall     (stall1),
`endif
        .in_ready  (ready1),
        .data_out  (data1),
        .sel_out   (sel1),
        .bit_valid (bv1),
        .bit_last  (bl1),
        .word_cnt  (cnt1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        in_valid0 = v0;
        in_data0  = d0;
        in_valid1 = v1;
        in_data1  = d1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        stall0     = 1'b0;
        stall1     = 1'b0;
        // mux out for 8'b10011101, index 0 first (bit i of exp_lsb is step i)
        exp_lsb = 8'b1001_1101;
        // mux out for index 7 first: 1,0,0,1,1,1,0,1 as steps 0..7
        exp_msb = 8'b1011_1001;

        // ---------------- reset values ----------------
        resetDut();
        checkOutput("rst_data",  {24'd0, data0}, 32'h00);
        checkOutput("rst_sel",   {29'd0, sel0},  32'd0);
        checkOutput("rst_valid", {31'd0, bv0},   32'd0);
        checkOutput("rst_last",  {31'd0, bl0},   32'd0);
        checkOutput("rst_cnt",   {24'd0, cnt0},  32'd0);
        checkOutput("rst_ready", {31'd0, ready0}, 32'd1);
        checkOutput("rst_sel1",  {29'd0, sel1},  32'd0);

        // ---------------- LSB-first single word ----------------
        applyStimulus(1'b1, 8'b1001_1101, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("lsb_sel%0d", i),   {29'd0, sel0}, i);
            checkOutput($sformatf("lsb_valid%0d", i), {31'd0, bv0},  32'd1);
            checkOutput($sformatf("lsb_last%0d", i),  {31'd0, bl0},  (i == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("lsb_mux%0d", i),   {31'd0, data0[sel0]}, {31'd0, exp_lsb[i]});
            checkOutput($sformatf("lsb_ready%0d", i), {31'd0, ready0}, (i == 7) ? 32'd1 : 32'd0);
            step();
        end
        checkOutput("lsb_done_valid", {31'd0, bv0},    32'd0);
        checkOutput("lsb_done_last",  {31'd0, bl0},    32'd0);
        checkOutput("lsb_done_ready", {31'd0, ready0}, 32'd1);
        checkOutput("lsb_done_cnt",   {24'd0, cnt0},   32'd1);
        checkOutput("lsb_hold_sel",   {29'd0, sel0},   32'd7);
        checkOutput("lsb_hold_data",  {24'd0, data0},  32'h9D);

        // ---------------- MSB-first single word ----------------
        applyStimulus(1'b0, 8'h00, 1'b1, 8'b1001_1101);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("msb_sel%0d", i),   {29'd0, sel1}, 7 - i);
            checkOutput($sformatf("msb_valid%0d", i), {31'd0, bv1},  32'd1);
            checkOutput($sformatf("msb_last%0d", i),  {31'd0, bl1},  (i == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("msb_mux%0d", i),   {31'd0, data1[sel1]}, {31'd0, exp_msb[i]});
            step();
        end
        checkOutput("msb_done_valid", {31'd0, bv1},    32'd0);
        checkOutput("msb_done_cnt",   {24'd0, cnt1},   32'd1);
        checkOutput("msb_done_ready", {31'd0, ready1}, 32'd1);
        checkOutput("msb_hold_sel",   {29'd0, sel1},   32'd0);

        // ---------------- back-to-back words ----------------
        resetDut();
        applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
        step();
        applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("b2b_sel%0d", i),   {29'd0, sel0}, i % 8);
            checkOutput($sformatf("b2b_valid%0d", i), {31'd0, bv0},  32'd1);
            checkOutput($sformatf("b2b_data%0d", i),  {24'd0, data0}, (i < 8) ? 32'hA5 : 32'h3C);
            if (i == 8) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            step();
        end
        checkOutput("b2b_cnt",   {24'd0, cnt0}, 32'd2);
        checkOutput("b2b_valid", {31'd0, bv0},  32'd0);

        // ---------------- asynchronous reset mid-scan ----------------
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) step();
        checkOutput("mid_sel_before", {29'd0, sel0}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_sel",   {29'd0, sel0},   32'd0);
        checkOutput("mid_data",  {24'd0, data0},  32'h00);
        checkOutput("mid_valid", {31'd0, bv0},    32'd0);
        checkOutput("mid_cnt",   {24'd0, cnt0},   32'd0);
        checkOutput("mid_ready", {31'd0, ready0}, 32'd1);
        step();
        #2;
        rst_n = 1'b1;
        step();
        applyStimulus(1'b1, 8'hF0, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("mid_reload_sel",   {29'd0, sel0},  32'd0);
        checkOutput("mid_reload_valid", {31'd0, bv0},   32'd1);
        checkOutput("mid_reload_data",  {24'd0, data0}, 32'hF0);
        repeat (8) step();
        checkOutput("mid_reload_cnt", {24'd0, cnt0}, 32'd1);

        // ---------------- word counter wrap ----------------
        resetDut();
        applyStimulus(1'b1, 8'h77, 1'b0, 8'h00);
        repeat (2041) step();
        checkOutput("wrap_cnt255", {24'd0, cnt0}, 32'd255);
        repeat (8) step();
        checkOutput("wrap_cnt0",   {24'd0, cnt0}, 32'd0);
        checkOutput("wrap_valid",  {31'd0, bv0},  32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (8) step();
        checkOutput("wrap_cnt1",   {24'd0, cnt0}, 32'd1);
        checkOutput("wrap_idle",   {31'd0, bv0},  32'd0);

`ifdef MUX_SEL_SCANNER_STALL_EN
        // ---------------- stall at sel=2 ----------------
        resetDut();
        applyStimulus(1'b1, 8'b1001_1101, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2) step();
        stall0 = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("stall_sel%0d", j),   {29'd0, sel0},   32'd2);
            checkOutput($sformatf("stall_valid%0d", j), {31'd0, bv0},    32'd0);
            checkOutput($sformatf("stall_ready%0d", j), {31'd0, ready0}, 32'd0);
            if (j == 2) stall0 = 1'b0;
            step();
        end
        for (int i = 3; i < 8; i++) begin
            checkOutput($sformatf("stall_res_sel%0d", i), {29'd0, sel0}, i);
            checkOutput($sformatf("stall_res_mux%0d", i), {31'd0, data0[sel0]}, {31'd0, exp_lsb[i]});
            checkOutput($sformatf("stall_res_valid%0d", i), {31'd0, bv0}, 32'd1);
            step();
        end
        checkOutput("stall_cnt",  {24'd0, cnt0}, 32'd1);
        checkOutput("stall_idle", {31'd0, bv0},  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
